// File: rtl/w_tile_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// w_tile_addr_gen_pkg
// Shared definitions for the weight tile address generator:
//   - default lane count (S2P) and its log2
//   - walk FSM state encoding
//   - lane_mask(): "count minus one" -> thermometer lane mask
// Optional feature macro used by the top: W_TILE_ADDR_GEN_PERF_EN.
// -----------------------------------------------------------------------------
package w_tile_addr_gen_pkg;

  localparam int S2P_DEF      = 8;
  localparam int S2P_LOG2_DEF = $clog2(S2P_DEF);

  // Widest lane mask lane_mask() can build; callers cast down to S2P bits.
  localparam int MASK_MAX_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lane mask for a tile edge. When is_edge is clear, or cnt_m1 >= width-1,
  // all width lanes are valid; otherwise only the low cnt_m1+1 lanes are.
  function automatic logic [MASK_MAX_W-1:0] lane_mask(
    input logic                  is_edge,
    input logic [MASK_MAX_W-1:0] cnt_m1,
    input int                    width
  );
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if ((i < width) &&
          (!is_edge || (cnt_m1 >= MASK_MAX_W'(width - 1)) || (MASK_MAX_W'(i) <= cnt_m1))) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/w_tile_addr_ctr.sv
// -----------------------------------------------------------------------------
// w_tile_addr_ctr
// Nested row-block / column-block counters plus the tile address accumulator.
// Column block is the inner loop. Row stride is S2P*iww, built with a shift.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           return to tile (0,0), address 0
//   step            advance to the next tile
//   bcn             column-block count minus 1 (captured copy)
//   iww             words per kernel row (captured copy)
//   nxt_row_blk     row block of the tile after the current one
//   nxt_col_blk     column block of the tile after the current one
//   nxt_addr        base address of the tile after the current one
// -----------------------------------------------------------------------------
module w_tile_addr_ctr
  import w_tile_addr_gen_pkg::*;
#(
  parameter int S2P    = S2P_DEF,
  parameter int ADDR_W = 16,
  parameter int IWW_W  = 16,
  parameter int BCN_W  = 16,
  parameter int BRN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [BCN_W-1:0]  bcn,
  input  logic [IWW_W-1:0]  iww,
  output logic [BRN_W-1:0]  nxt_row_blk,
  output logic [BCN_W-1:0]  nxt_col_blk,
  output logic [ADDR_W-1:0] nxt_addr
);

  localparam int LOG2 = $clog2(S2P);
  localparam int SW   = IWW_W + LOG2;

  logic [BRN_W-1:0]  row_blk_r;
  logic [BCN_W-1:0]  col_blk_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] nxt_base_s;
  logic [SW-1:0]     stride_full_s;
  logic [ADDR_W-1:0] stride_s;

  // S2P*iww as a left shift, then wrapped into the address space.
  assign stride_full_s = {iww, {LOG2{1'b0}}};
  assign stride_s      = ADDR_W'(stride_full_s);

  // Next tile position: step the column, or wrap to the next row's base.
  always_comb begin
    nxt_row_blk = row_blk_r;
    nxt_col_blk = col_blk_r;
    nxt_base_s  = row_base_r;
    nxt_addr    = addr_r;
    if (col_blk_r < bcn) begin
      nxt_col_blk = col_blk_r + BCN_W'(1);
      nxt_addr    = addr_r + ADDR_W'(S2P);
    end else begin
      nxt_col_blk = '0;
      nxt_row_blk = row_blk_r + BRN_W'(1);
      nxt_base_s  = row_base_r + stride_s;
      nxt_addr    = row_base_r + stride_s;
    end
  end

  // Counter and accumulator state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_blk_r  <= '0;
      col_blk_r  <= '0;
      row_base_r <= '0;
      addr_r     <= '0;
    end else if (step) begin
      row_blk_r  <= nxt_row_blk;
      col_blk_r  <= nxt_col_blk;
      row_base_r <= nxt_base_s;
      addr_r     <= nxt_addr;
    end else begin
      row_blk_r  <= row_blk_r;
      col_blk_r  <= col_blk_r;
      row_base_r <= row_base_r;
      addr_r     <= addr_r;
    end
  end

endmodule

// File: rtl/w_tile_addr_gen.sv
// -----------------------------------------------------------------------------
// w_tile_addr_gen
// Walks the weight matrix (kernel_nums rows x K*K*C columns) in S2P x S2P
// tiles after a rising edge of i_enable, emitting one registered tile
// descriptor per valid/ready handshake, row block outer, column block inner.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_enable            rising edge launches a walk; low aborts a walk
//   i_bcn/i_brn/i_iww   column blocks-1, row blocks, words per kernel row
//   i_knr/i_iwwr        last row / column block lane count minus 1
//   o_valid/i_ready     descriptor handshake
//   o_addr              tile base address in weight SRAM
//   o_row_mask          valid kernel lanes, o_col_mask valid element lanes
//   o_last              final tile of the walk
//   o_done              one-cycle pulse after the final tile is accepted
//   o_stall_cnt         (W_TILE_ADDR_GEN_PERF_EN) RUN cycles stalled by i_ready
//   o_tile_cnt          (W_TILE_ADDR_GEN_PERF_EN) accepted tiles
// Optional feature macro: W_TILE_ADDR_GEN_PERF_EN.
// -----------------------------------------------------------------------------
module w_tile_addr_gen
  import w_tile_addr_gen_pkg::*;
#(
  parameter int S2P    = S2P_DEF,
  parameter int ADDR_W = 16,
  parameter int IWW_W  = 16,
  parameter int BCN_W  = 16,
  parameter int BRN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [BCN_W-1:0]  i_bcn,
  input  logic [BRN_W-1:0]  i_brn,
  input  logic [IWW_W-1:0]  i_iww,
  input  logic [S2P-1:0]    i_knr,
  input  logic [S2P-1:0]    i_iwwr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [S2P-1:0]    o_row_mask,
  output logic [S2P-1:0]    o_col_mask,
  output logic              o_last,
  output logic              o_done
`ifdef W_TILE_ADDR_GEN_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_tile_cnt
`endif
);

  state_t            state_r, state_s;
  logic              en_r, rise_r;
  logic [BCN_W-1:0]  cap_bcn_r;
  logic [BRN_W-1:0]  cap_brn_r;
  logic [IWW_W-1:0]  cap_iww_r;
  logic [S2P-1:0]    cap_knr_r, cap_iwwr_r;

  logic              capture_s, clear_s, step_s, accept_s;
  logic              valid_s, last_s, done_s;
  logic [ADDR_W-1:0] addr_s;
  logic [S2P-1:0]    row_mask_s, col_mask_s;

  logic [BRN_W-1:0]  nxt_row_blk_s;
  logic [BCN_W-1:0]  nxt_col_blk_s;
  logic [ADDR_W-1:0] nxt_addr_s;

  logic              launch_row_edge_s, launch_col_edge_s, launch_last_s;
  logic              step_row_edge_s, step_col_edge_s, step_last_s;
  logic [S2P-1:0]    launch_rm_s, launch_cm_s, step_rm_s, step_cm_s;

  w_tile_addr_ctr #(
    .S2P    (S2P),
    .ADDR_W (ADDR_W),
    .IWW_W  (IWW_W),
    .BCN_W  (BCN_W),
    .BRN_W  (BRN_W)
  ) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_s),
    .step        (step_s),
    .bcn         (cap_bcn_r),
    .iww         (cap_iww_r),
    .nxt_row_blk (nxt_row_blk_s),
    .nxt_col_blk (nxt_col_blk_s),
    .nxt_addr    (nxt_addr_s)
  );

  // The first descriptor is built from the live inputs in the same cycle they
  // are captured, so the tile appears without an extra cycle of latency.
  assign launch_row_edge_s = (i_brn == BRN_W'(1));
  assign launch_col_edge_s = (i_bcn == BCN_W'(0));
  assign launch_last_s     = launch_row_edge_s && launch_col_edge_s;
  assign launch_rm_s       = S2P'(lane_mask(launch_row_edge_s, MASK_MAX_W'(i_knr), S2P));
  assign launch_cm_s       = S2P'(lane_mask(launch_col_edge_s, MASK_MAX_W'(i_iwwr), S2P));

  // Later descriptors come from the counter's look-ahead and captured params.
  assign step_row_edge_s   = (nxt_row_blk_s == cap_brn_r - BRN_W'(1));
  assign step_col_edge_s   = (nxt_col_blk_s == cap_bcn_r);
  assign step_last_s       = step_row_edge_s && step_col_edge_s;
  assign step_rm_s         = S2P'(lane_mask(step_row_edge_s, MASK_MAX_W'(cap_knr_r), S2P));
  assign step_cm_s         = S2P'(lane_mask(step_col_edge_s, MASK_MAX_W'(cap_iwwr_r), S2P));

  // Enable history and its registered rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r   <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      en_r   <= i_enable;
      rise_r <= i_enable & ~en_r;
    end
  end

  // Walk parameters, frozen at launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_bcn_r  <= '0;
      cap_brn_r  <= '0;
      cap_iww_r  <= '0;
      cap_knr_r  <= '0;
      cap_iwwr_r <= '0;
    end else if (capture_s) begin
      cap_bcn_r  <= i_bcn;
      cap_brn_r  <= i_brn;
      cap_iww_r  <= i_iww;
      cap_knr_r  <= i_knr;
      cap_iwwr_r <= i_iwwr;
    end else begin
      cap_bcn_r  <= cap_bcn_r;
      cap_brn_r  <= cap_brn_r;
      cap_iww_r  <= cap_iww_r;
      cap_knr_r  <= cap_knr_r;
      cap_iwwr_r <= cap_iwwr_r;
    end
  end

  // Next state and next registered descriptor; outputs idle at zero.
  always_comb begin
    state_s    = state_r;
    valid_s    = 1'b0;
    addr_s     = '0;
    row_mask_s = '0;
    col_mask_s = '0;
    last_s     = 1'b0;
    done_s     = 1'b0;
    capture_s  = 1'b0;
    clear_s    = 1'b0;
    step_s     = 1'b0;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_r) begin
          capture_s = 1'b1;
          clear_s   = 1'b1;
          if (i_brn == BRN_W'(0)) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s    = ST_RUN;
            valid_s    = 1'b1;
            row_mask_s = launch_rm_s;
            col_mask_s = launch_cm_s;
            last_s     = launch_last_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_s = ST_IDLE;
        end else if (o_valid && i_ready) begin
          accept_s = 1'b1;
          if (o_last) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            step_s     = 1'b1;
            valid_s    = 1'b1;
            addr_s     = nxt_addr_s;
            row_mask_s = step_rm_s;
            col_mask_s = step_cm_s;
            last_s     = step_last_s;
          end
        end else begin
          valid_s    = o_valid;
          addr_s     = o_addr;
          row_mask_s = o_row_mask;
          col_mask_s = o_col_mask;
          last_s     = o_last;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered descriptor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      o_valid    <= 1'b0;
      o_addr     <= '0;
      o_row_mask <= '0;
      o_col_mask <= '0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_r    <= state_s;
      o_valid    <= valid_s;
      o_addr     <= addr_s;
      o_row_mask <= row_mask_s;
      o_col_mask <= col_mask_s;
      o_last     <= last_s;
      o_done     <= done_s;
    end
  end

`ifdef W_TILE_ADDR_GEN_PERF_EN
  // Saturating stall and accepted-tile counters, cleared at each launch.
  always_ff @(posedge clk) begin
    if (rst || capture_s) begin
      o_stall_cnt <= 32'd0;
      o_tile_cnt  <= 32'd0;
    end else begin
      if ((state_r == ST_RUN) && o_valid && !i_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end else begin
        o_stall_cnt <= o_stall_cnt;
      end
      if (accept_s && (o_tile_cnt != 32'hFFFF_FFFF)) begin
        o_tile_cnt <= o_tile_cnt + 32'd1;
      end else begin
        o_tile_cnt <= o_tile_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_w_tile_addr_gen.sv
// Self-checking bench for w_tile_addr_gen (S2P=8, 16-bit addresses).
// Expected tiles are generated by push_walk() into a scoreboard queue and
// popped as the DUT presents accepted descriptors.
module tb_w_tile_addr_gen;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_bcn;
  logic [7:0]  i_brn;
  logic [15:0] i_iww;
  logic [7:0]  i_knr;
  logic [7:0]  i_iwwr;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_addr;
  logic [7:0]  o_row_mask;
  logic [7:0]  o_col_mask;
  logic        o_last;
  logic        o_done;
`ifdef W_TILE_ADDR_GEN_PERF_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_tile_cnt;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  rm;
    logic [7:0]  cm;
    logic        last;
  } tile_t;

  tile_t exp_q[$];
  int n_tests;
  int n_fail;

  w_tile_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_bcn      (i_bcn),
    .i_brn      (i_brn),
    .i_iww      (i_iww),
    .i_knr      (i_knr),
    .i_iwwr     (i_iwwr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_addr     (o_addr),
    .o_row_mask (o_row_mask),
    .o_col_mask (o_col_mask),
    .o_last     (o_last),
    .o_done     (o_done)
`ifdef W_TILE_ADDR_GEN_PERF_EN
    ,
    .o_stall_cnt (o_stall_cnt),
    .o_tile_cnt  (o_tile_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference walk: row block outer, column block inner.
  function automatic void push_walk(input int brn, input int bcn, input int iww,
                                    input int knr, input int iwwr);
    tile_t t;
    for (int r = 0; r < brn; r++) begin
      for (int c = 0; c <= bcn; c++) begin
        t.addr = 16'(r * 8 * iww + c * 8);
        t.rm   = (r == brn - 1 && knr < 7)  ? 8'(32'd255 >> (7 - knr))  : 8'hFF;
        t.cm   = (c == bcn && iwwr < 7)     ? 8'(32'd255 >> (7 - iwwr)) : 8'hFF;
        t.last = (r == brn - 1 && c == bcn);
        exp_q.push_back(t);
      end
    end
  endfunction

  // Drive parameters and raise i_enable just after a falling edge.
  task automatic launch(input logic [7:0] brn, input logic [15:0] bcn, input logic [15:0] iww,
                        input logic [7:0] knr, input logic [7:0] iwwr);
    @(negedge clk);
    i_brn    = brn;
    i_bcn    = bcn;
    i_iww    = iww;
    i_knr    = knr;
    i_iwwr   = iwwr;
    i_enable = 1'b1;
  endtask

  task automatic end_walk();
    @(negedge clk);
    i_enable = 1'b0;
    i_ready  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_valid, o_addr, o_row_mask, o_col_mask, o_last, o_done} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b addr=%h rm=%h cm=%h last=%b done=%b, want all 0",
               o_valid, o_addr, o_row_mask, o_col_mask, o_last, o_done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    tile_t e;
    int k_last, k_done, n_done;
    exp_q.delete();
    push_walk(1, 3, 27, 255, 2);
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    k_last = -10; k_done = -10; n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      i_ready = 1'b1;
      if (k == 3) begin
        i_iww = 16'd99;  // must be ignored by the running walk
        i_bcn = 16'd0;
      end
      if (k == 0) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++; $display("FAIL basic_latency_early: o_valid=%b, want 0", o_valid);
        end
      end
      if (k == 1) begin
        n_tests++;
        if (o_valid !== 1'b1) begin
          n_fail++; $display("FAIL basic_latency: o_valid=%b, want 1", o_valid);
        end
      end
      if (o_done === 1'b1) begin n_done++; k_done = k; end
      if (o_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL basic_extra_tile: addr=%h, want no tile", o_addr);
        end else begin
          e = exp_q.pop_front();
          if ({o_addr, o_row_mask, o_col_mask, o_last} !== {e.addr, e.rm, e.cm, e.last}) begin
            n_fail++;
            $display("FAIL basic_tile: got addr=%h rm=%h cm=%h last=%b, want addr=%h rm=%h cm=%h last=%b",
                     o_addr, o_row_mask, o_col_mask, o_last, e.addr, e.rm, e.cm, e.last);
          end
          if (e.last) k_last = k;
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_missing: %0d tiles left, want 0", exp_q.size());
    end
    n_tests++;
    if (n_done != 1 || k_done != k_last + 1) begin
      n_fail++; $display("FAIL basic_done: pulses=%0d at %0d, want 1 at %0d", n_done, k_done, k_last + 1);
    end
    end_walk();
  endtask

  task automatic test_two_rows();
    tile_t e;
    int n_done, n_tiles;
    exp_q.delete();
    push_walk(2, 0, 8, 3, 255);
    launch(8'd2, 16'd0, 16'd8, 8'd3, 8'hFF);
    n_done = 0; n_tiles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_ready = 1'b1;
      if (o_done === 1'b1) n_done++;
      if (o_valid === 1'b1) begin
        n_tiles++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rows_extra_tile: addr=%h, want no tile", o_addr);
        end else begin
          e = exp_q.pop_front();
          if ({o_addr, o_row_mask, o_col_mask, o_last} !== {e.addr, e.rm, e.cm, e.last}) begin
            n_fail++;
            $display("FAIL rows_tile: got addr=%h rm=%h cm=%h last=%b, want addr=%h rm=%h cm=%h last=%b",
                     o_addr, o_row_mask, o_col_mask, o_last, e.addr, e.rm, e.cm, e.last);
          end
        end
      end
    end
    n_tests++;
    if (n_tiles != 2 || n_done != 1) begin
      n_fail++; $display("FAIL rows_count: tiles=%0d done=%0d, want 2 and 1", n_tiles, n_done);
    end
    end_walk();
  endtask

  task automatic test_backpressure();
    tile_t e;
    logic [32:0] saved;
    bit have_saved;
    int phase, n_done;
    exp_q.delete();
    push_walk(1, 3, 27, 255, 2);
    i_ready = 1'b0;
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    phase = 0; have_saved = 1'b0; n_done = 0; saved = '0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      i_ready = (o_valid === 1'b1) && (phase == 2);
      if (o_done === 1'b1) n_done++;
      if (o_valid === 1'b1 && have_saved) begin
        n_tests++;
        if ({o_addr, o_row_mask, o_col_mask, o_last} !== saved) begin
          n_fail++; $display("FAIL bp_hold: got %h, want %h", {o_addr, o_row_mask, o_col_mask, o_last}, saved);
        end
      end
      if (o_valid === 1'b1 && !i_ready) begin
        saved = {o_addr, o_row_mask, o_col_mask, o_last};
        have_saved = 1'b1;
        phase++;
      end else if (o_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_tile: addr=%h, want no tile", o_addr);
        end else begin
          e = exp_q.pop_front();
          if ({o_addr, o_row_mask, o_col_mask, o_last} !== {e.addr, e.rm, e.cm, e.last}) begin
            n_fail++;
            $display("FAIL bp_tile: got addr=%h rm=%h cm=%h last=%b, want addr=%h rm=%h cm=%h last=%b",
                     o_addr, o_row_mask, o_col_mask, o_last, e.addr, e.rm, e.cm, e.last);
          end
        end
        phase = 0;
        have_saved = 1'b0;
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || n_done != 1) begin
      n_fail++; $display("FAIL bp_complete: left=%0d done=%0d, want 0 and 1", exp_q.size(), n_done);
    end
`ifdef W_TILE_ADDR_GEN_PERF_EN
    n_tests++;
    if (o_stall_cnt !== 32'd8 || o_tile_cnt !== 32'd4) begin
      n_fail++; $display("FAIL bp_perf: stall=%0d tiles=%0d, want 8 and 4", o_stall_cnt, o_tile_cnt);
    end
`endif
    end_walk();
  endtask

  task automatic test_abort();
    tile_t e;
    int n_acc, n_done, abort_k;
    exp_q.delete();
    push_walk(1, 3, 27, 255, 2);
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    n_acc = 0; n_done = 0; abort_k = -10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i_ready = (abort_k < 0);
      if (o_done === 1'b1) n_done++;
      if (k == abort_k + 1) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++; $display("FAIL abort_valid: o_valid=%b, want 0", o_valid);
        end
      end
      if (n_acc == 2 && abort_k < 0) begin
        i_enable = 1'b0;
        i_ready  = 1'b0;
        abort_k  = k;
      end else if (o_valid === 1'b1 && i_ready === 1'b1) begin
        e = exp_q.pop_front();
        n_acc++;
        n_tests++;
        if (o_addr !== e.addr) begin
          n_fail++; $display("FAIL abort_tile: addr=%h, want %h", o_addr, e.addr);
        end
      end
    end
    n_tests++;
    if (n_done != 0 || n_acc != 2) begin
      n_fail++; $display("FAIL abort_nodone: done=%0d accepted=%0d, want 0 and 2", n_done, n_acc);
    end
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || o_addr !== 16'h0000) begin
      n_fail++; $display("FAIL abort_restart: valid=%b addr=%h, want 1 and 0000", o_valid, o_addr);
    end
    end_walk();
  endtask

  task automatic test_zero_rows();
    int n_valid, n_done, k_done;
    launch(8'd0, 16'd3, 16'd27, 8'hFF, 8'd2);
    n_valid = 0; n_done = 0; k_done = -10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_ready = 1'b1;
      if (o_valid === 1'b1) n_valid++;
      if (o_done === 1'b1) begin n_done++; k_done = k; end
    end
    n_tests++;
    if (n_valid != 0 || n_done != 1 || k_done != 1) begin
      n_fail++; $display("FAIL zero_rows: valid=%0d done=%0d at %0d, want 0, 1 at 1", n_valid, n_done, k_done);
    end
    end_walk();
  endtask

  task automatic test_reset_mid();
    int n_valid;
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    n_valid = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      i_ready = (k == 1);
      if (k == 2) begin
        rst = 1'b1;
        i_enable = 1'b0;
      end
      if (k == 3) begin
        rst = 1'b0;
        n_tests++;
        if ({o_valid, o_addr, o_row_mask, o_col_mask, o_last, o_done} !== 35'd0) begin
          n_fail++;
          $display("FAIL rst_mid_outputs: got valid=%b addr=%h rm=%h cm=%h last=%b done=%b, want all 0",
                   o_valid, o_addr, o_row_mask, o_col_mask, o_last, o_done);
        end
`ifdef W_TILE_ADDR_GEN_PERF_EN
        n_tests++;
        if (o_stall_cnt !== 32'd0 || o_tile_cnt !== 32'd0) begin
          n_fail++; $display("FAIL rst_mid_perf: stall=%0d tiles=%0d, want 0", o_stall_cnt, o_tile_cnt);
        end
`endif
      end
      if (k > 3 && o_valid === 1'b1) n_valid++;
    end
    n_tests++;
    if (n_valid != 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: %0d valid cycles, want 0", n_valid);
    end
    launch(8'd1, 16'd3, 16'd27, 8'hFF, 8'd2);
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || o_addr !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_restart: valid=%b addr=%h, want 1 and 0000", o_valid, o_addr);
    end
    end_walk();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_enable = 1'b0;
    i_ready  = 1'b0;
    i_bcn    = 16'd0;
    i_brn    = 8'd0;
    i_iww    = 16'd0;
    i_knr    = 8'd0;
    i_iwwr   = 8'd0;
    test_reset();
    test_basic();
    test_two_rows();
    test_backpressure();
    test_abort();
    test_zero_rows();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
